// File: rtl/dp_controller_pkg.sv
// Shared definitions for the dp_controller sequencer: FSM states,
// instruction field positions and ALUControl op codes.
package dp_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int HALT_BIT = 9;
  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 6;
  localparam int A1_MSB   = 5;
  localparam int A1_LSB   = 4;
  localparam int A2_MSB   = 3;
  localparam int A2_LSB   = 2;
  localparam int A3_MSB   = 1;
  localparam int A3_LSB   = 0;

  // Op codes follow the attached ALU's decode table.
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  function automatic logic [9:0] mk_instr(input logic       halt,
                                          input logic [2:0] op,
                                          input logic [1:0] a1,
                                          input logic [1:0] a2,
                                          input logic [1:0] a3);
    return {halt, op, a1, a2, a3};
  endfunction

endpackage

// File: rtl/dp_controller_prog_mem.sv
// Instruction store for dp_controller: synchronous write, combinational read,
// contents deliberately untouched by reset.
module dp_prog_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 10
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [IW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [IW-1:0]            o_rdata
);

  logic [IW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dp_controller.sv
// Micro-sequencer driving a register-file/ALU datapath: FETCH/EXEC/WRITE per
// instruction. Optional OVERFLOW_TRAP_EN aborts the program on ALU overflow.
module dp_controller
  import dp_controller_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int IW         = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [IW-1:0]                 prog_data,
  output logic                          wr,
  output logic [2:0]                    ALUControl,
  output logic [1:0]                    addr1,
  output logic [1:0]                    addr2,
  output logic [1:0]                    addr3,
  input  logic                          Zero,
  input  logic                          Overflow,
  output logic [7:0]                    instr_count,
  output logic                          last_zero
);

  localparam int AW = $clog2(PROG_DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_ir;
  logic [IW-1:0] w_fetch;
  logic [7:0]    r_count;
  logic          r_last_zero;
  logic [2:0]    r_hold_op;
  logic [1:0]    r_hold_a1;
  logic [1:0]    r_hold_a2;
  logic [1:0]    r_hold_a3;
  logic          w_mem_we;
  logic          w_trap;
  logic          w_live;

  assign w_mem_we = prog_we && (r_state == ST_IDLE);

  dp_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .IW    (IW)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_fetch)
  );

`ifdef OVERFLOW_TRAP_EN
  logic r_err;

  assign w_trap = Overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_EXEC) && Overflow) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_trap = 1'b0 & Overflow;
  assign err    = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_FETCH;
      ST_FETCH: w_next = w_fetch[HALT_BIT] ? ST_DONE : ST_EXEC;
      ST_EXEC:  w_next = w_trap ? ST_DONE : ST_WRITE;
      ST_WRITE: w_next = (r_pc == AW'(PROG_DEPTH - 1)) ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_count     <= '0;
      r_last_zero <= 1'b0;
      r_hold_op   <= '0;
      r_hold_a1   <= '0;
      r_hold_a2   <= '0;
      r_hold_a3   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc    <= '0;
            r_count <= '0;
          end
        end
        ST_FETCH: r_ir <= w_fetch;
        ST_EXEC: begin
          r_last_zero <= Zero;
          // Snapshot the live fields so they persist once ir is refetched.
          r_hold_op   <= r_ir[OP_MSB:OP_LSB];
          r_hold_a1   <= r_ir[A1_MSB:A1_LSB];
          r_hold_a2   <= r_ir[A2_MSB:A2_LSB];
          r_hold_a3   <= r_ir[A3_MSB:A3_LSB];
        end
        ST_WRITE: begin
          r_pc <= r_pc + AW'(1);
          if (r_count != 8'hFF) r_count <= r_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // A halt word in ir never reaches EXEC, so fields only go live for real ops.
  assign w_live = ((r_state == ST_EXEC) || (r_state == ST_WRITE)) && !r_ir[HALT_BIT];

  assign ALUControl  = w_live ? r_ir[OP_MSB:OP_LSB] : r_hold_op;
  assign addr1       = w_live ? r_ir[A1_MSB:A1_LSB] : r_hold_a1;
  assign addr2       = w_live ? r_ir[A2_MSB:A2_LSB] : r_hold_a2;
  assign addr3       = w_live ? r_ir[A3_MSB:A3_LSB] : r_hold_a3;
  assign wr          = (r_state == ST_WRITE);
  assign busy        = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_WRITE);
  assign done        = (r_state == ST_DONE);
  assign instr_count = r_count;
  assign last_zero   = r_last_zero;

endmodule

// File: tb/tb_dp_controller.sv
// Scoreboard bench for dp_controller: directed programs push expected wr/done
// events; a negedge monitor pops and compares them as the DUT emits them.
module tb_dp_controller;
  import dp_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [9:0] prog_data = '0;
  logic       Zero = 1'b0;
  logic       Overflow = 1'b0;
  logic       busy, done, err, wr, last_zero;
  logic [2:0] ALUControl;
  logic [1:0] addr1, addr2, addr3;
  logic [7:0] instr_count;

  dp_controller #(.PROG_DEPTH(16), .IW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .wr          (wr),
    .ALUControl  (ALUControl),
    .addr1       (addr1),
    .addr2       (addr2),
    .addr3       (addr3),
    .Zero        (Zero),
    .Overflow    (Overflow),
    .instr_count (instr_count),
    .last_zero   (last_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    int         rel;
    logic [2:0] alu;
    logic [1:0] a1, a2, a3;
    bit         lz;
    int         cnt;
    bit         er;
    int         bcyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int rel, input logic [2:0] op, input logic [1:0] x,
                         input logic [1:0] y, input logic [1:0] z, input bit lz);
    exp_t e;
    e = '{is_done: 1'b0, rel: rel, alu: op, a1: x, a2: y, a3: z, lz: lz, cnt: 0, er: 1'b0, bcyc: 0};
    q.push_back(e);
  endtask

  task automatic push_done(input int rel, input int cnt, input bit er, input bit lz, input int bc);
    exp_t e;
    e = '{is_done: 1'b1, rel: rel, alu: 3'b0, a1: 2'b0, a2: 2'b0, a3: 2'b0, lz: lz, cnt: cnt, er: er, bcyc: bc};
    q.push_back(e);
  endtask

  // Monitor: every wr or done pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_cnt++;
    if (wr === 1'b1 || done === 1'b1) begin
      if (q.size() == 0) begin
        if (wr === 1'b1) chk("unexpected_wr", 1, 0);
        else chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("event_is_done", int'(done), int'(e.is_done));
        chk("event_cycle", cyc - start_cyc, e.rel);
        chk("last_zero", int'(last_zero), int'(e.lz));
        if (e.is_done) begin
          chk("done_instr_count", int'(instr_count), e.cnt);
          chk("done_err", int'(err), int'(e.er));
          chk("done_busy_cycles", busy_cnt, e.bcyc);
        end else begin
          chk("wr_ALUControl", int'(ALUControl), int'(e.alu));
          chk("wr_addr1", int'(addr1), int'(e.a1));
          chk("wr_addr2", int'(addr2), int'(e.a2));
          chk("wr_addr3", int'(addr3), int'(e.a3));
        end
      end
    end
    if (busy !== 1'b1) busy_cnt = 0;
  end

  task automatic load(input int a, input logic [9:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a[3:0];
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [3:0] iv;

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr", int'(wr), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_instr_count", int'(instr_count), 0);
    chk("rst_last_zero", int'(last_zero), 0);
    chk("rst_ALUControl", int'(ALUControl), 0);
    chk("rst_addr1", int'(addr1), 0);
    chk("rst_addr2", int'(addr2), 0);
    chk("rst_addr3", int'(addr3), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      iv = i[3:0];
      load(i, mk_instr(1'b0, ALU_ADD, iv[1:0], iv[3:2], ~iv[1:0]));
    end

    // Abort mid-program: reset lands on the edge that would enter WRITE.
    start_run();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wr", int'(wr), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Full wrap through all 16 slots; program memory survived the reset.
    for (int i = 0; i < 16; i++) begin
      iv = i[3:0];
      push_wr(3 + 3 * i, ALU_ADD, iv[1:0], iv[3:2], ~iv[1:0], 1'b0);
    end
    push_done(49, 16, 1'b0, 1'b0, 48);
    start_run();
    wait_done(100);
    chk("wrap_pc", int'(dut.r_pc), 0);
    @(negedge clk);

    // Single AND followed by halt.
    load(0, mk_instr(1'b0, ALU_AND, 2'd2, 2'd3, 2'd1));
    load(1, mk_instr(1'b1, ALU_PASS, 2'd0, 2'd0, 2'd0));
    push_wr(3, ALU_AND, 2'd2, 2'd3, 2'd1, 1'b0);
    push_done(5, 1, 1'b0, 1'b0, 4);
    start_run();
    wait_done(20);
    chk("and_instr_count", int'(instr_count), 1);
    chk("idle_hold_addr1", int'(addr1), 2);
    @(negedge clk);

    // SUB R1,R1 -> R0 with the datapath reporting Zero.
    load(0, mk_instr(1'b0, ALU_SUB, 2'd1, 2'd1, 2'd0));
    Zero = 1'b1;
    push_wr(3, ALU_SUB, 2'd1, 2'd1, 2'd0, 1'b1);
    push_done(5, 1, 1'b0, 1'b1, 4);
    start_run();
    wait_done(20);
    Zero = 1'b0;
    @(negedge clk);

    // Overflow raised on the first instruction.
    load(0, mk_instr(1'b0, ALU_ADD, 2'd1, 2'd2, 2'd3));
    Overflow = 1'b1;
`ifdef OVERFLOW_TRAP_EN
    push_done(3, 0, 1'b1, 1'b0, 2);
`else
    push_wr(3, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0);
    push_done(5, 1, 1'b0, 1'b0, 4);
`endif
    start_run();
    wait_done(20);
    Overflow = 1'b0;
    @(negedge clk);

    // start and prog_we while busy are both ignored.
    load(0, mk_instr(1'b0, ALU_AND, 2'd2, 2'd3, 2'd1));
    push_wr(3, ALU_AND, 2'd2, 2'd3, 2'd1, 1'b0);
    push_done(5, 1, 1'b0, 1'b0, 4);
    start_run();
    start     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = mk_instr(1'b0, ALU_OR, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    wait_done(20);
    @(negedge clk);

    push_wr(3, ALU_AND, 2'd2, 2'd3, 2'd1, 1'b0);
    push_done(5, 1, 1'b0, 1'b0, 4);
    start_run();
    wait_done(20);
    repeat (3) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dp_controller.md
DP_CONTROLLER -- requirements
Module: dp_controller

Interface
REQ-001 Parameters SHALL be: PROG_DEPTH, 16, program-memory entries (power of two); IW, 10, instruction width.
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-003 Ports SHALL be: start  in  1  run request; busy  out  1  program running; done  out  1  one-cycle completion pulse; err  out  1  sticky overflow trap flag.
REQ-004 Ports SHALL be: prog_we  in  1  program write; prog_addr  in  log2(PROG_DEPTH)  write index; prog_data  in  IW  instruction.
REQ-005 Datapath-side ports SHALL be: wr  out  1  register write; ALUControl  out  3  ALU op; addr1/addr2  out  2  source regs; addr3  out  2  destination reg; Zero  in  1; Overflow  in  1.
REQ-006 Ports SHALL be: instr_count  out  8  retired instructions; last_zero  out  1  Zero sampled at last EXEC.

Function
REQ-007 Instruction fields SHALL be: [9] halt, [8:6] ALUControl, [5:4] addr1, [3:2] addr2, [1:0] addr3.
REQ-008 FSM states SHALL be IDLE, FETCH, EXEC, WRITE, DONE.
REQ-009 IDLE: start=1 SHALL clear pc, instr_count and err, then enter FETCH; start while not IDLE SHALL be ignored.
REQ-010 FETCH: ir SHALL load prog_mem[pc]; next state EXEC, or DONE if the fetched halt bit is 1 (no execution, no count).
REQ-011 EXEC: addr1/addr2/addr3/ALUControl SHALL be driven from ir with wr=0; Zero SHALL be captured into last_zero and Overflow SHALL be sampled.
REQ-012 WRITE: wr SHALL be 1 for exactly one cycle with the same fields held; pc and instr_count SHALL increment.
REQ-013 After WRITE: if pc was PROG_DEPTH-1 (wrap boundary), next state SHALL be DONE; otherwise FETCH.
REQ-014 The latency per non-halt instruction SHALL be 3 cycles (FETCH, EXEC, WRITE).
REQ-015 DONE: done=1 for one cycle, then IDLE; busy SHALL be 1 in FETCH, EXEC and WRITE only.
REQ-016 instr_count SHALL saturate at 255.
REQ-017 prog_we SHALL write prog_mem only in IDLE; writes while busy SHALL be dropped.
REQ-018 In IDLE, FETCH and DONE, wr SHALL be 0 and address/ALUControl outputs SHALL hold their last values.

Reset
REQ-019 rst SHALL force, at the next edge: state IDLE, pc=0, ir=0, wr=0, busy=0, done=0, err=0, instr_count=0, last_zero=0, ALUControl=0, addr1=addr2=addr3=0.
REQ-020 prog_mem contents SHALL NOT be cleared by rst.
REQ-021 rst asserted mid-program SHALL abort it without a done pulse, and no wr SHALL occur in the following cycle.

Configuration
REQ-022 With OVERFLOW_TRAP_EN defined, Overflow=1 in EXEC SHALL set err, skip WRITE (no register write, no count) and go to DONE.
REQ-023 Without OVERFLOW_TRAP_EN, Overflow SHALL be ignored, err SHALL be tied 0, and WRITE SHALL always follow EXEC.

Structure
REQ-024 A shared package SHALL hold the state enum, the instruction field positions and the ALUControl op codes (AND=010, matching the ALU).
REQ-025 Program memory SHALL be a separate sub-module, dp_prog_mem (synchronous write, combinational read).

Verification
REQ-026 Reset: rst=1 for 1 cycle during a running program -> wr=0 and busy=0 next cycle, no done pulse.
REQ-027 Single AND: prog[0]=0_010_10_11_01, prog[1]=halt; start -> wr=1 exactly at cycle 3 with addr1=2, addr2=3, addr3=1, ALUControl=010; done at cycle 5; instr_count=1.
REQ-028 Full wrap: 16 non-halt ADD instructions -> 48 busy cycles, done pulse, instr_count=16, pc back to 0.
REQ-029 Trap (OVERFLOW_TRAP_EN): datapath forced Overflow=1 on instr 0 -> err=1, no wr pulse, done, instr_count=0; same stimulus without the macro -> wr pulse, err=0.
REQ-030 Handshake: start pulsed while busy and prog_we while busy -> ignored; prog_mem unchanged, program completes normally.
REQ-031 Zero: SUB R1,R1 -> R0 with Zero=1 -> last_zero=1 after EXEC.
